mac_engine: RTL

MAC_ENGINE -- requirements
Module: mac_engine

---
 rtl/mac_engine_if.sv | 45 ++++
 rtl/mac_engine.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_engine_if.sv
// ---------------------------------------------------------------------------
// mac_engine_if
//   Groups the tap-input and result-output handshake of mac_engine.
//
//   Parameters : DATA_W, ACC_W, TAP_CNT. They must match the engine that is
//                attached to the interface.
//   Signals    : clear        synchronous abort of the current frame
//                signed_mode  1 = two's-complement operands for this tap
//                in_valid     tap offered
//                in_ready     tap accepted when in_valid && in_ready
//                x, y         operands
//                out_valid    result holds a completed sum
//                out_ready    consumer takes result when out_valid && out_ready
//                result       completed TAP_CNT-product sum
//                tap_idx      products already summed into the current frame
//   Modports   : master = producer/consumer side, slave = the engine.
// ---------------------------------------------------------------------------
interface mac_engine_if #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 32,
    parameter int TAP_CNT = 9
);
    localparam int IDX_W = (TAP_CNT > 1) ? $clog2(TAP_CNT) : 1;

    logic              clear;
    logic              signed_mode;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  result;
    logic [IDX_W-1:0]  tap_idx;

    modport master (
        output clear, signed_mode, in_valid, x, y, out_ready,
        input  in_ready, out_valid, result, tap_idx
    );

    modport slave (
        input  clear, signed_mode, in_valid, x, y, out_ready,
        output in_ready, out_valid, result, tap_idx
    );
endinterface

// File: rtl/mac_engine.sv
// ---------------------------------------------------------------------------
// mac_engine
//   Two-stage multiply-accumulate engine. Each accepted X/Y tap is multiplied
//   in stage 1; stage 2 accumulates TAP_CNT products into one frame sum and
//   presents it on result with a valid/ready handshake. Back-to-back frames
//   run at one tap per clock.
//
//   Ports  : i_clk    the only clock, rising edge
//            i_rst_n  asynchronous active-low reset
//            bus      mac_engine_if.slave (clear, signed_mode, in_valid,
//                     in_ready, x, y, out_valid, out_ready, result, tap_idx)
//
//   Optional build macro:
//     MAC_SATURATE_EN  when defined, stage 2 clamps the running sum to the
//                      representable limit of the tap's mode and holds that
//                      value until the frame completes. When undefined the
//                      accumulator wraps modulo 2^ACC_W.
//
//   ACC_W must be at least 2*DATA_W.
// ---------------------------------------------------------------------------
module mac_engine #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 32,
    parameter int TAP_CNT = 9
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    mac_engine_if.slave  bus
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int IDX_W  = (TAP_CNT > 1) ? $clog2(TAP_CNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAP_CNT - 1);

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    logic w_stall;
    logic w_in_ready;
    logic w_accept;

    logic r_out_valid;
    logic [ACC_W-1:0] r_result;

    // A held result that nobody takes freezes the whole pipeline.
    assign w_stall    = r_out_valid && !bus.out_ready;
    assign w_in_ready = !w_stall && !bus.clear;
    assign w_accept   = bus.in_valid && w_in_ready;

    // -----------------------------------------------------------------------
    // Stage 1: product
    // -----------------------------------------------------------------------
    logic              w_ext_sign_x;
    logic              w_ext_sign_y;
    logic [PROD_W-1:0] w_x_ext;
    logic [PROD_W-1:0] w_y_ext;
    logic [PROD_W-1:0] w_prod;
    logic              w_prod_sign;
    logic [ACC_W-1:0]  w_product;

    // Operands are widened according to the tap's mode before multiplying.
    // The low PROD_W bits of the product of the widened operands are the
    // exact product in either mode, since the true result always fits.
    assign w_ext_sign_x = bus.signed_mode & bus.x[DATA_W-1];
    assign w_ext_sign_y = bus.signed_mode & bus.y[DATA_W-1];
    assign w_x_ext      = {{DATA_W{w_ext_sign_x}}, bus.x};
    assign w_y_ext      = {{DATA_W{w_ext_sign_y}}, bus.y};
    assign w_prod       = w_x_ext * w_y_ext;
    assign w_prod_sign  = bus.signed_mode & w_prod[PROD_W-1];

    generate
        if (ACC_W > PROD_W) begin : g_prod_ext
            assign w_product = {{(ACC_W - PROD_W){w_prod_sign}}, w_prod};
        end else begin : g_prod_fit
            assign w_product = w_prod;
        end
    endgenerate

    logic             r_s1_valid;
    logic [ACC_W-1:0] r_s1_prod;

    // -----------------------------------------------------------------------
    // Stage 2: accumulate
    // -----------------------------------------------------------------------
    logic [ACC_W-1:0] r_acc;
    logic [IDX_W-1:0] r_tap_idx;
    logic [ACC_W-1:0] w_base;
    logic [ACC_W-1:0] w_sum;
    logic             w_last;
    logic             w_advance;
    logic             w_complete;

    // The first product of a frame loads the accumulator instead of adding.
    assign w_base     = (r_tap_idx == '0) ? '0 : r_acc;
    assign w_last     = (r_tap_idx == LAST_IDX);
    assign w_advance  = r_s1_valid && !w_stall && !bus.clear;
    assign w_complete = w_advance && w_last;

`ifdef MAC_SATURATE_EN
    localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W - 1){1'b1}}};
    localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W - 1){1'b0}}};

    logic             r_s1_signed;
    logic             r_sat;
    logic [ACC_W:0]   w_add_wide;
    logic             w_ovf_u;
    logic             w_ovf_s;
    logic             w_sat_hold;
    logic             w_sat_now;

    assign w_add_wide = {1'b0, w_base} + {1'b0, r_s1_prod};
    assign w_ovf_u    = w_add_wide[ACC_W];
    // Signed overflow: both addends share a sign the sum does not.
    assign w_ovf_s    = (w_base[ACC_W-1] == r_s1_prod[ACC_W-1]) &&
                        (w_add_wide[ACC_W-1] != r_s1_prod[ACC_W-1]);
    // Once clamped, the value sticks until the frame is emitted.
    assign w_sat_hold = r_sat && (r_tap_idx != '0);

    always_comb begin
        w_sum     = w_add_wide[ACC_W-1:0];
        w_sat_now = 1'b0;
        if (w_sat_hold) begin
            w_sum     = r_acc;
            w_sat_now = 1'b1;
        end else if (r_s1_signed && w_ovf_s) begin
            w_sum     = w_base[ACC_W-1] ? SMIN : SMAX;
            w_sat_now = 1'b1;
        end else if (!r_s1_signed && w_ovf_u) begin
            w_sum     = '1;
            w_sat_now = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_signed <= 1'b0;
            r_sat       <= 1'b0;
        end else if (bus.clear) begin
            r_sat       <= 1'b0;
        end else if (!w_stall) begin
            if (bus.in_valid) begin
                r_s1_signed <= bus.signed_mode;
            end
            if (r_s1_valid) begin
                r_sat <= w_last ? 1'b0 : w_sat_now;
            end
        end
    end
`else
    assign w_sum = w_base + r_s1_prod;
`endif

    // -----------------------------------------------------------------------
    // Pipeline state
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_prod  <= '0;
            r_acc      <= '0;
            r_tap_idx  <= '0;
        end else if (bus.clear) begin
            // Abort wins over a stall: the partial frame is dropped even
            // while a finished result is still waiting to be taken.
            r_s1_valid <= 1'b0;
            r_acc      <= '0;
            r_tap_idx  <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_prod <= w_product;
            end
            if (r_s1_valid) begin
                if (w_last) begin
                    r_acc     <= '0;
                    r_tap_idx <= '0;
                end else begin
                    r_acc     <= w_sum;
                    r_tap_idx <= r_tap_idx + IDX_W'(1);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Result register. clear never touches it. Outside a stall, out_valid
    // either fell through a handshake or was low already, so the new value
    // is simply whether a frame completes now; a completion coinciding with
    // a handshake replaces result and keeps out_valid high.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else if (!w_stall) begin
            r_out_valid <= w_complete;
            if (w_complete) begin
                r_result <= w_sum;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.tap_idx   = r_tap_idx;

endmodule
